proc_run_sequencer: RTL and testbench

PROC_RUN_SEQUENCER -- requirements
Module: proc_run_sequencer

---
 rtl/proc_run_sequencer.sv | 140 ++++++++++++++
 tb/tb_proc_run_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/proc_run_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | proc_run_sequencer: resets a processor, runs it to an end PC or watchdog,  |
// | then captures and checks one data-memory result word.   Rev 1.0           |
// +----------------------------------------------------------------------------+
module proc_run_sequencer #(
  parameter int unsigned RESET_CYCLES = 1,
  parameter int unsigned DRAIN_CYCLES = 1,
  parameter logic [15:0] WATCHDOG_MAX = 16'hFFFF
) (
  input  logic        CLK,
  input  logic        Reset_L,
  input  logic        start,
  input  logic [63:0] start_pc,
  input  logic [63:0] end_pc,
  input  logic [63:0] expected,
  input  logic [63:0] currentPC,
  input  logic [63:0] dMemOut,
  output logic        proc_reset_l,
  output logic [63:0] proc_start_pc,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [15:0] cycles,
  output logic [63:0] result
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HOLD    = 3'd1,
    S_RUN     = 3'd2,
    S_DRAIN   = 3'd3,
    S_CHECK   = 3'd4,
    S_DONE    = 3'd5,
    S_TIMEOUT = 3'd6
  } state_t;

  localparam logic [3:0] c_reset_cycles = 4'(RESET_CYCLES);
  localparam logic [3:0] c_drain_cycles = 4'(DRAIN_CYCLES);

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic [63:0] r_end_pc, w_end_pc_nxt;
  logic [63:0] r_expected, w_expected_nxt;
  logic [63:0] w_start_pc_nxt;
  logic [15:0] w_cycles_nxt;
  logic [63:0] w_result_nxt;
  logic        w_pass_nxt;
  logic        w_busy_nxt, w_proc_reset_l_nxt, w_done_nxt, w_timeout_nxt;

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_end_pc_nxt   = r_end_pc;
    w_expected_nxt = r_expected;
    w_start_pc_nxt = proc_start_pc;
    w_cycles_nxt   = cycles;
    w_result_nxt   = result;
    w_pass_nxt     = pass;
    case (r_state)
      S_IDLE, S_DONE, S_TIMEOUT: begin
        if (start) begin
          w_start_pc_nxt = start_pc;
          w_end_pc_nxt   = end_pc;
          w_expected_nxt = expected;
          w_cycles_nxt   = 16'd0;
          w_result_nxt   = 64'd0;
          w_pass_nxt     = 1'b0;
          w_cnt_nxt      = c_reset_cycles;
          w_state_nxt    = S_HOLD;
        end
      end
      S_HOLD: begin
        if (r_cnt <= 4'd1) w_state_nxt = S_RUN;
        else               w_cnt_nxt   = r_cnt - 4'd1;
      end
      S_RUN: begin
        // End-PC takes priority so a run finishing on the watchdog cycle still completes.
        if (currentPC >= r_end_pc) begin
          w_cnt_nxt   = c_drain_cycles;
          w_state_nxt = S_DRAIN;
        end else if (cycles == WATCHDOG_MAX) begin
          w_pass_nxt  = 1'b0;
          w_state_nxt = S_TIMEOUT;
        end else begin
          w_cycles_nxt = cycles + 16'd1;
        end
      end
      S_DRAIN: begin
        if (r_cnt <= 4'd1) w_state_nxt = S_CHECK;
        else               w_cnt_nxt   = r_cnt - 4'd1;
      end
      S_CHECK: begin
        w_result_nxt = dMemOut;
        w_pass_nxt   = (dMemOut == r_expected);
        w_state_nxt  = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Status outputs are decoded from the next state so they register in step with it.
    w_busy_nxt         = w_state_nxt inside {S_HOLD, S_RUN, S_DRAIN, S_CHECK};
    w_proc_reset_l_nxt = w_state_nxt inside {S_RUN, S_DRAIN, S_CHECK};
    w_done_nxt         = w_state_nxt inside {S_DONE, S_TIMEOUT};
    w_timeout_nxt      = (w_state_nxt == S_TIMEOUT);
  end

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      r_state       <= S_IDLE;
      r_cnt         <= 4'd0;
      r_end_pc      <= 64'd0;
      r_expected    <= 64'd0;
      proc_reset_l  <= 1'b0;
      proc_start_pc <= 64'd0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      timeout       <= 1'b0;
      cycles        <= 16'd0;
      result        <= 64'd0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_end_pc      <= w_end_pc_nxt;
      r_expected    <= w_expected_nxt;
      proc_reset_l  <= w_proc_reset_l_nxt;
      proc_start_pc <= w_start_pc_nxt;
      busy          <= w_busy_nxt;
      done          <= w_done_nxt;
      pass          <= w_pass_nxt;
      timeout       <= w_timeout_nxt;
      cycles        <= w_cycles_nxt;
      result        <= w_result_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_proc_run_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_proc_run_sequencer: scoreboard bench with a stepping-PC processor model.|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_proc_run_sequencer;
  localparam int          R = 3;
  localparam int          D = 2;
  localparam logic [15:0] W = 16'd40;

  logic        CLK = 1'b0;
  logic        Reset_L = 1'b1;
  logic        start = 1'b0;
  logic [63:0] start_pc = 64'd0, end_pc = 64'd0, expected = 64'd0, dMemOut = 64'd0;
  logic [63:0] pc = 64'd0, step = 64'd0;
  logic        proc_reset_l, busy, done, pass, timeout;
  logic [63:0] proc_start_pc, result;
  logic [15:0] cycles;

  proc_run_sequencer #(.RESET_CYCLES(R), .DRAIN_CYCLES(D), .WATCHDOG_MAX(W)) dut (
    .CLK(CLK), .Reset_L(Reset_L), .start(start), .start_pc(start_pc), .end_pc(end_pc),
    .expected(expected), .currentPC(pc), .dMemOut(dMemOut), .proc_reset_l(proc_reset_l),
    .proc_start_pc(proc_start_pc), .busy(busy), .done(done), .pass(pass),
    .timeout(timeout), .cycles(cycles), .result(result)
  );

  always #5 CLK = ~CLK;

  // Processor stand-in: loads the start PC while held in reset, then advances by step.
  always @(posedge CLK) begin
    if (!proc_reset_l) pc <= proc_start_pc;
    else               pc <= pc + step;
  end

  typedef struct {
    logic [63:0] result;
    logic        pass;
    logic        to;
    logic [15:0] cyc;
    int          busy_cyc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  // Monitor: counts busy and processor-reset cycles, scores each completed run.
  initial begin
    int   busy_n;
    int   low_n;
    logic prev_done;
    exp_t e;
    busy_n = 0; low_n = 0; prev_done = 1'b0;
    forever begin
      @(negedge CLK);
      if (!Reset_L) begin
        busy_n = 0; low_n = 0; prev_done = 1'b0;
      end else begin
        if (busy) begin
          busy_n++;
          if (!proc_reset_l) low_n++;
        end
        if (done && !prev_done) begin
          if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_done: done=1 with no run outstanding");
          end else begin
            e = q.pop_front();
            chk("result",       result,        e.result);
            chk("pass",         64'(pass),     64'(e.pass));
            chk("timeout",      64'(timeout),  64'(e.to));
            chk("cycles",       64'(cycles),   64'(e.cyc));
            chk("busy_at_done", 64'(busy),     64'd0);
            chk("proc_rst_done",64'(proc_reset_l), 64'd0);
            chk("busy_cycles",  64'(busy_n),   64'(e.busy_cyc));
            chk("hold_cycles",  64'(low_n),    64'(R));
          end
          busy_n = 0; low_n = 0;
        end
        prev_done = done;
      end
    end
  end

  task automatic run_one(input logic [63:0] s, input logic [63:0] e_pc, input logic [63:0] p,
                         input logic [63:0] dm, input logic [63:0] ex, input bit inject);
    exp_t e;
    bit   found;
    int   k;
    int   bc;
    found = 1'b0; k = 0;
    for (int i = 0; i <= int'(W); i++)
      if (!found && (s + p * 64'(i)) >= e_pc) begin found = 1'b1; k = i; end
    if (found) begin
      e.cyc = 16'(k); e.to = 1'b0; e.result = dm; e.pass = (dm == ex);
      e.busy_cyc = R + (k + 1) + D + 1;
    end else begin
      e.cyc = W; e.to = 1'b1; e.result = 64'd0; e.pass = 1'b0;
      e.busy_cyc = R + int'(W) + 1;
    end
    @(negedge CLK);
    start_pc = s; end_pc = e_pc; expected = ex; dMemOut = dm; step = p; start = 1'b1;
    q.push_back(e);
    @(negedge CLK);
    start = 1'b0;
    chk("acc_busy",    64'(busy),         64'd1);
    chk("acc_done",    64'(done),         64'd0);
    chk("acc_pass",    64'(pass),         64'd0);
    chk("acc_timeout", 64'(timeout),      64'd0);
    chk("acc_cycles",  64'(cycles),       64'd0);
    chk("acc_result",  result,            64'd0);
    chk("acc_proc_rst",64'(proc_reset_l), 64'd0);
    chk("acc_start_pc",proc_start_pc,     s);
    bc = 1;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge CLK);
      bc++;
      start = 1'b0;
      if (inject && found && k >= 1 && (bc == R + 2 || bc == R + k + 2)) begin
        start = 1'b1;
        start_pc = {$urandom, $urandom}; end_pc = 64'd0; expected = ~ex;
      end
    end
    start = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL run_wait: done never rose, got 0, required 1");
    end
    repeat ($urandom_range(0, 3)) @(negedge CLK);
  endtask

  task automatic reset_mid_run();
    @(negedge CLK);
    start_pc = 64'h40; end_pc = 64'h400; expected = 64'h1; step = 64'd4; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (R + 4) @(negedge CLK);
    #2 Reset_L = 1'b0;
    #1;
    chk("rst_busy",     64'(busy),         64'd0);
    chk("rst_proc_rst", 64'(proc_reset_l), 64'd0);
    chk("rst_start_pc", proc_start_pc,     64'd0);
    chk("rst_cycles",   64'(cycles),       64'd0);
    chk("rst_done",     64'(done),         64'd0);
    repeat (2) @(negedge CLK);
    Reset_L = 1'b1;
    repeat (3) @(negedge CLK);
    chk("post_rst_idle", 64'(busy), 64'd0);
  endtask

  initial begin
    logic [63:0] s, e_pc, p, ex, dm;
    #1 Reset_L = 1'b0;
    #1;
    chk("reset_proc_rst", 64'(proc_reset_l), 64'd0);
    chk("reset_start_pc", proc_start_pc,     64'd0);
    chk("reset_flags",    {60'd0, busy, done, pass, timeout}, 64'd0);
    chk("reset_cycles",   64'(cycles),       64'd0);
    chk("reset_result",   result,            64'd0);
    repeat (2) @(negedge CLK);
    Reset_L = 1'b1;
    repeat (3) @(negedge CLK);
    chk("idle_no_start", 64'(busy), 64'd0);

    run_one(64'd0, 64'h74, 64'd4, 64'h123456789abcdef0, 64'h123456789abcdef0, 1'b0);
    run_one(64'd0, 64'h74, 64'd4, 64'hF,                64'h123456789abcdef0, 1'b1);
    run_one(64'd0, 64'h74, 64'd0, 64'h5,                64'h5,                1'b0);
    run_one(64'd0, 64'd4 * 64'(W),          64'd4, 64'h77, 64'h77, 1'b0);
    run_one(64'd0, 64'd4 * 64'(W) + 64'd4,  64'd4, 64'h77, 64'h77, 1'b0);
    run_one(64'h100, 64'h80, 64'd4, 64'h9, 64'h9, 1'b0);
    run_one(64'hFFFF_FFFF_FFFF_FF00, 64'h8000_0000_0000_0000, 64'd4, 64'h1, 64'h2, 1'b0);
    run_one(64'h10, 64'hFFFF_FFFF_FFFF_FFF0, 64'd0, 64'h3, 64'h3, 1'b0);
    reset_mid_run();
    run_one(64'h20, 64'h60, 64'd8, 64'hABC, 64'hABC, 1'b1);

    for (int n = 0; n < 24; n++) begin
      s  = 64'($urandom_range(0, 4095));
      p  = ($urandom_range(0, 5) == 0) ? 64'd0 : 64'($urandom_range(1, 16));
      if (p == 64'd0) e_pc = s + 64'($urandom_range(0, 8));
      else            e_pc = s + p * 64'($urandom_range(0, int'(W) + 4)) + 64'($urandom_range(0, 3));
      ex = {$urandom, $urandom};
      dm = $urandom_range(0, 1) ? ex : {$urandom, $urandom};
      run_one(s, e_pc, p, dm, ex, $urandom_range(0, 2) == 0);
    end

    repeat (4) @(negedge CLK);
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
